// File: rtl/round_sat_pipe.sv
// round_sat_pipe: two-stage multi-lane requantiser Q(2I.2F) -> Q(I.F).
// Each lane rounds in S1 using the mode that came with its beat. S2 clamps
// the result and raises a flag. A sticky counter tracks delivered beats in
// which any lane was clamped.

// One lane: S1 rounds, S2 saturates. The parent supplies the load enables.
module round_sat_lane #(
  parameter int IW = 32,
  parameter int OW = 16,
  parameter int F  = 9,
  parameter int RW = IW - F + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld1,
  input  logic          ld2,
  input  logic [IW-1:0] x_i,
  input  logic [1:0]    mode_i,
  output logic [OW-1:0] y_o,
  output logic          sat_o
);
  logic [RW-1:0] t, r_d, r_q;
  logic [OW-1:0] y_d, y_q;
  logic          sat_d, sat_q;
  logic          g, s, l, neg, inc;

  // S1: arithmetic truncate, then add the increment selected by the mode.
  // The carry is kept in the wide word, so a round-up past max still clamps.
  always_comb begin
    t   = RW'($signed(x_i) >>> F);
    g   = x_i[F-1];
    s   = |x_i[F-2:0];
    l   = x_i[F];
    neg = x_i[IW-1];
    inc = 1'b0;
    case (mode_i)
      2'b00:   inc = 1'b0;
      2'b01:   inc = g;
      2'b10:   inc = g & (s | l);
      default: inc = neg & (g | s);
    endcase
    r_d = ld1 ? (t + {{(RW-1){1'b0}}, inc}) : r_q;
  end

  // S2: the value fits when bits [RW-1:OW-1] are all equal. Otherwise clamp
  // toward the sign.
  always_comb begin
    y_d   = y_q;
    sat_d = sat_q;
    if (ld2) begin
      if (!r_q[RW-1] && (|r_q[RW-2:OW-1])) begin
        y_d   = {1'b0, {(OW-1){1'b1}}};
        sat_d = 1'b1;
      end else if (r_q[RW-1] && !(&r_q[RW-2:OW-1])) begin
        y_d   = {1'b1, {(OW-1){1'b0}}};
        sat_d = 1'b1;
      end else begin
        y_d   = r_q[OW-1:0];
        sat_d = 1'b0;
      end
    end
  end

  // Lane stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      y_q   <= y_d;
      sat_q <= sat_d;
    end
  end

  assign y_o   = y_q;
  assign sat_o = sat_q;
endmodule

module round_sat_pipe #(
  parameter int para_int_bits  = 7,
  parameter int para_frac_bits = 9,
  parameter int LANES          = 4,
  parameter int CNT_W          = 16
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            in_valid_i,
  output logic                                            in_ready_o,
  input  logic [LANES*2*(para_int_bits+para_frac_bits)-1:0] in_data_i,
  input  logic [1:0]                                      mode_i,
  output logic                                            out_valid_o,
  input  logic                                            out_ready_i,
  output logic [LANES*(para_int_bits+para_frac_bits)-1:0] out_data_o,
  output logic [LANES-1:0]                                out_sat_o,
  input  logic                                            sat_cnt_clr_i,
  output logic [CNT_W-1:0]                                sat_cnt_o
);
  localparam int OW = para_int_bits + para_frac_bits;
  localparam int IW = 2 * OW;
  localparam int RW = IW - para_frac_bits + 1;

  logic [2:1]                vld_pipe_d, vld_pipe_q;
  logic                      rdy1, rdy2, ld1, ld2;
  logic [LANES-1:0][OW-1:0]  y;
  logic [LANES-1:0]          sat;
  logic [CNT_W-1:0]          cnt_d, cnt_q;

  // Handshake: a stage may take a beat when it is empty or is being drained.
  // Data registers load only for real beats, so a stall leaves them unchanged.
  always_comb begin
    rdy2       = !vld_pipe_q[2] || out_ready_i;
    rdy1       = !vld_pipe_q[1] || rdy2;
    ld1        = rdy1 && in_valid_i;
    ld2        = rdy2 && vld_pipe_q[1];
    vld_pipe_d = vld_pipe_q;
    if (rdy1) vld_pipe_d[1] = in_valid_i;
    if (rdy2) vld_pipe_d[2] = vld_pipe_q[1];
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    round_sat_lane #(.IW(IW), .OW(OW), .F(para_frac_bits), .RW(RW)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .ld1    (ld1),
      .ld2    (ld2),
      .x_i    (in_data_i[k*IW +: IW]),
      .mode_i (mode_i),
      .y_o    (y[k]),
      .sat_o  (sat[k])
    );
  end

  // Saturation-event counter: a clear wins, and the count holds at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (sat_cnt_clr_i)
      cnt_d = '0;
    else if (vld_pipe_q[2] && out_ready_i && (|sat) && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Valid bits and the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      cnt_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready_o  = rdy1;
  assign out_valid_o = vld_pipe_q[2];
  assign out_data_o  = y;
  assign out_sat_o   = sat;
  assign sat_cnt_o   = cnt_q;
endmodule

// File: tb/tb_round_sat_pipe.sv
// tb_round_sat_pipe: directed scoreboard bench for round_sat_pipe (I=7, F=9, 4 lanes).
module tb_round_sat_pipe;
  localparam int LANES = 4;
  localparam int OW = 16;
  localparam int IW = 32;

  typedef struct packed {
    logic [LANES-1:0]    sat;
    logic [LANES*OW-1:0] data;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, clr = 1'b0;
  logic [LANES*IW-1:0]  in_data = '0;
  logic [1:0]           mode = 2'b00;
  logic [LANES*OW-1:0]  out_data;
  logic [LANES-1:0]     out_sat;
  logic [15:0]          sat_cnt;

  logic                 in_valid2 = 1'b0, in_ready2, out_valid2;
  logic [LANES*IW-1:0]  in_data2 = {LANES{32'h7FFFFFFF}};
  logic [LANES*OW-1:0]  out_data2;
  logic [LANES-1:0]     out_sat2;
  logic [1:0]           sat_cnt2;

  exp_t exp_q[$];
  int   cmps = 0, errs = 0, pops = 0, cyc = 0, occ = 0;
  logic hold_v = 1'b0;
  exp_t held;

  round_sat_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .mode_i(mode), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_sat_o(out_sat), .sat_cnt_clr_i(clr), .sat_cnt_o(sat_cnt));

  round_sat_pipe #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .in_data_i(in_data2), .mode_i(2'b00), .out_valid_o(out_valid2), .out_ready_i(1'b1),
    .out_data_o(out_data2), .out_sat_o(out_sat2), .sat_cnt_clr_i(1'b0), .sat_cnt_o(sat_cnt2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    cmps++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: integer floor/remainder arithmetic. Returns {sat, data}.
  function automatic logic [16:0] model(input logic [31:0] x, input logic [1:0] m);
    longint v  = longint'($signed(x));
    longint fl = v >>> 9;
    longint fr = v - fl * 512;
    longint r  = fl;
    case (m)
      2'd1: if (fr >= 256) r++;
      2'd2: if (fr > 256 || (fr == 256 && fl[0])) r++;
      2'd3: if (v < 0 && fr != 0) r++;
      default: ;
    endcase
    if (r > 32767)  return {1'b1, 16'h7FFF};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  function automatic exp_t ex(input logic [15:0] v, input logic s);
    return {{LANES{s}}, {LANES{v}}};
  endfunction

  // Monitor: scoreboard pop, stall stability, in_ready against occupancy.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      occ = 0;
      hold_v = 1'b0;
    end else begin
      chk("in_ready", in_ready, !(occ == 2 && !out_ready));
      if (out_valid) begin
        if (hold_v) chk("stall_stable", {out_sat, out_data}, held);
        hold_v = !out_ready;
        held   = {out_sat, out_data};
      end else hold_v = 1'b0;
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          cmps++; errs++;
          $error("FAIL unexpected_beat: observed %h expected none", {out_sat, out_data});
        end else begin
          e = exp_q.pop_front();
          chk("beat", {out_sat, out_data}, e);
        end
      end
      occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
    end
  end

  task automatic send(input logic [LANES*IW-1:0] d, input logic [1:0] m, input exp_t e);
    int n = 0;
    in_valid = 1'b1; in_data = d; mode = m;
    exp_q.push_back(e);
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      cmps++; errs++;
      $error("FAIL accept_timeout: observed no accept expected accept");
    end
    @(posedge clk); #1;
  endtask

  task automatic send_m(input logic [LANES*IW-1:0] d, input logic [1:0] m);
    exp_t e;
    logic [16:0] r;
    for (int k = 0; k < LANES; k++) begin
      r = model(d[k*IW +: IW], m);
      e.data[k*OW +: OW] = r[15:0];
      e.sat[k] = r[16];
    end
    send(d, m, e);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = {LANES{$urandom}};
    mode     = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin
      cmps++; errs++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [LANES*IW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int c0, p0;
    logic [3:0] pat = 4'b1001;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_cnt", sat_cnt, 16'h0);
    chk("rst_data", {out_sat, out_data}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // latency: accept at edge n, valid after edge n+1
    send_m(rnd(), 2'b01);
    idle();
    chk("lat_n", out_valid, 1'b0);
    @(posedge clk); #1;
    chk("lat_n1", out_valid, 1'b1);
    drain();

    // rounding mode sweep and saturation corners
    send({LANES{32'h00000100}}, 2'b00, ex(16'h0000, 1'b0));
    send({LANES{32'h00000100}}, 2'b01, ex(16'h0001, 1'b0));
    send({LANES{32'h00000100}}, 2'b10, ex(16'h0000, 1'b0));
    send({LANES{32'h00000100}}, 2'b11, ex(16'h0000, 1'b0));
    send({LANES{32'h00000300}}, 2'b10, ex(16'h0002, 1'b0));
    send({LANES{32'hFFFFFF00}}, 2'b00, ex(16'hFFFF, 1'b0));
    send({LANES{32'hFFFFFF00}}, 2'b01, ex(16'h0000, 1'b0));
    send({LANES{32'hFFFFFF00}}, 2'b10, ex(16'h0000, 1'b0));
    send({LANES{32'hFFFFFF00}}, 2'b11, ex(16'h0000, 1'b0));
    send({LANES{32'h7FFFFFFF}}, 2'b00, ex(16'h7FFF, 1'b1));
    send({LANES{32'h80000000}}, 2'b11, ex(16'h8000, 1'b1));
    send({LANES{32'h00FFFF00}}, 2'b01, ex(16'h7FFF, 1'b1));
    send({LANES{32'h00FFFF00}}, 2'b00, ex(16'h7FFF, 1'b0));
    drain();

    // throughput: back-to-back beats, mode changes every beat
    c0 = cyc; p0 = pops;
    for (int k = 0; k < 12; k++) send_m(rnd(), 2'(k));
    chk("tput_in_cycles", 32'(cyc - c0), 32'd12);
    chk("tput_out_beats", 32'(pops - p0), 32'd10);
    drain();

    // backpressure: out_ready follows 1,0,0,1 repeating
    fork
      begin
        for (int k = 0; k < 8; k++) send_m(rnd(), 2'(k + 1));
        idle();
      end
      begin
        for (int j = 0; j < 40; j++) begin
          out_ready = pat[j % 4];
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // counter: three clamped beats, then clear together with a fourth
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("cnt_clr", sat_cnt, 16'd0);
    for (int k = 0; k < 3; k++)
      send_m({32'h00000001, 32'h7FFFFFFF, 32'h00000200, 32'h0}, 2'(k));
    drain();
    chk("cnt_3", sat_cnt, 16'd3);
    send_m({32'h80000000, 32'h0, 32'h0, 32'h0}, 2'b00);
    idle();
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("cnt_clr_prio", sat_cnt, 16'd0);
    chk("cnt_clr_beat_gone", 32'(exp_q.size()), 32'd0);
    send_m({LANES{32'h7FFFFFFF}}, 2'b00);
    drain();
    chk("cnt_1", sat_cnt, 16'd1);

    // reset with both stages full
    out_ready = 1'b0;
    send_m(rnd(), 2'b10);
    send_m(rnd(), 2'b11);
    idle();
    chk("full_not_ready", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_cnt", sat_cnt, 16'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_m({32'h00000300, 32'hFFFFFF00, 32'h7FFFFFFF, 32'h00012345}, 2'b10);
    idle();
    chk("postrst_lat_n", out_valid, 1'b0);
    @(posedge clk); #1;
    chk("postrst_lat_n1", out_valid, 1'b1);
    drain();

    // narrow counter build: 5 clamped beats hold at 3
    in_valid2 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("cnt2_hold", sat_cnt2, 2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
